// File: rtl/featuremap_channel_accum.sv
// Sums CH signed channel results per pixel, adds a loadable bias, then applies optional ReLU and saturation.
// Latency: two cycles from input transfer to out_data; throughput one pixel per cycle.
// Backpressure: a held output beat (out_valid & ~out_ready) freezes both stages and drops in_ready.
module featuremap_channel_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int CH         = 3,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112,
    parameter logic signed [DATA_WIDTH-1:0] BIAS_INIT = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH*CH-1:0] in_data,
    input  logic                     bias_we,
    input  logic [DATA_WIDTH-1:0]    bias_in,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_eol,
    output logic                     out_eof
);

    localparam int ACC_W = DATA_WIDTH + $clog2(CH) + 1;
    // One extra bit so that adding the bias to a full-scale channel sum cannot wrap.
    localparam int T_W   = ACC_W + 1;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);
    localparam logic signed [T_W-1:0] SAT_MAX =
        {{(T_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [T_W-1:0] SAT_MIN =
        {{(T_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                         s1_valid_q, s1_valid_d;
    logic signed [ACC_W-1:0]      s1_sum_q, s1_sum_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;

    logic                         en;
    logic                         xfer;
    logic signed [DATA_WIDTH-1:0] ch_v;
    logic signed [ACC_W-1:0]      ch_sum;
    logic signed [T_W-1:0]        biased;
    logic signed [DATA_WIDTH-1:0] sat;
    logic signed [DATA_WIDTH-1:0] pix;

    always_comb begin
        en   = ~out_valid_q | out_ready;
        xfer = out_valid_q & out_ready;

        ch_v   = '0;
        ch_sum = '0;
        for (int k = 0; k < CH; k++) begin
            ch_v   = in_data[DATA_WIDTH*k +: DATA_WIDTH];
            ch_sum = ch_sum + ACC_W'(ch_v);
        end

        biased = T_W'(s1_sum_q) + T_W'(bias_q);
        if (biased > SAT_MAX) begin
            sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (biased < SAT_MIN) begin
            sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat = biased[DATA_WIDTH-1:0];
        end
        pix = (relu_en && (sat < 0)) ? '0 : sat;

        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        bias_d      = bias_q;
        col_d       = col_q;
        row_d       = row_q;

        if (en) begin
            s1_valid_d  = in_valid;
            s1_sum_d    = ch_sum;
            out_valid_d = s1_valid_q;
            out_data_d  = pix;
        end

        // Stage 2 above reads bias_q, so a same-edge load only affects later captures.
        if (bias_we) begin
            bias_d = bias_in;
        end

        if (xfer) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            bias_q      <= BIAS_INIT;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            bias_q      <= bias_d;
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_eol   = out_valid_q & (col_q == COL_MAX);
    assign out_eof   = out_eol & (row_q == ROW_MAX);

endmodule

// File: tb/tb_featuremap_channel_accum.sv
// Directed bench for featuremap_channel_accum with an integer reference model and a per-cycle compare.
module tb_featuremap_channel_accum;

    localparam int DW = 16;
    localparam int CH = 3;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int BI = 7;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DW*CH-1:0]      in_data = '0;
    logic                  bias_we = 1'b0;
    logic [DW-1:0]         bias_in = '0;
    logic                  relu_en = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic signed [DW-1:0]  out_data;
    logic                  out_eol;
    logic                  out_eof;

    int checks   = 0;
    int failures = 0;

    int   log_d[$];
    logic log_eol[$];
    logic log_eof[$];

    featuremap_channel_accum #(
        .DATA_WIDTH(DW), .CH(CH), .WIDTH(W), .HEIGHT(H), .BIAS_INIT(16'sd7)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bias_we(bias_we), .bias_in(bias_in), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference arithmetic: plain integers, clamp to the signed output range, optional ReLU.
    function automatic int pix_val(input int s, input int b, input logic relu);
        int t;
        t = s + b;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        if (relu && t < 0) t = 0;
        return t;
    endfunction

    function automatic int sum_ch(input logic [DW*CH-1:0] d);
        int s;
        logic signed [DW-1:0] v;
        s = 0;
        for (int k = 0; k < CH; k++) begin
            v = d[DW*k +: DW];
            s = s + int'(v);
        end
        return s;
    endfunction

    // Model: two pixel slots that move forward whenever the output slot is empty or being taken.
    logic m_v1, m_v2;
    int   m_sum1, m_dat, m_bias, m_beats;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_v1    <= 1'b0;
            m_v2    <= 1'b0;
            m_sum1  <= 0;
            m_dat   <= 0;
            m_bias  <= BI;
            m_beats <= 0;
        end else begin
            if (m_v2 && out_ready) m_beats <= m_beats + 1;
            if (!m_v2 || out_ready) begin
                if (m_v1) m_dat <= pix_val(m_sum1, m_bias, relu_en);
                m_v2   <= m_v1;
                m_v1   <= in_valid;
                m_sum1 <= sum_ch(in_data);
            end
            if (bias_we) m_bias <= int'($signed(bias_in));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", in_ready, !m_v2 || out_ready);
            chk("out_valid", out_valid, m_v2);
            if (m_v2) chk("out_data", out_data, m_dat);
            chk("out_eol", out_eol, m_v2 && (m_beats % W == W - 1));
            chk("out_eof", out_eof, m_v2 && (m_beats % W == W - 1) && ((m_beats / W) % H == H - 1));
            if (out_valid && out_ready) begin
                log_d.push_back(int'(out_data));
                log_eol.push_back(out_eol);
                log_eof.push_back(out_eof);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c);
        logic ok;
        in_data  = {16'(c), 16'(b), 16'(a)};
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic load_bias(input int b);
        bias_we = 1'b1;
        bias_in = 16'(b);
        @(posedge clk);
        #1;
        bias_we = 1'b0;
    endtask

    initial begin
        logic signed [DW-1:0] held;
        logic found;
        int base;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_eol", out_eol, 0);
        @(posedge clk);
        #1;

        // Basic sum with bias 5 and latency
        load_bias(5);
        send(100, -20, 7);
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_cycle2_data", out_data, 92);
        @(posedge clk);
        #1;
        idle(2);

        // Saturation and ReLU
        load_bias(0);
        send(32767, 32767, 1);
        idle(3);
        send(-32768, -32768, 0);
        idle(3);
        relu_en = 1'b1;
        send(-32768, -32768, 0);
        send(10, 0, 0);
        idle(3);
        relu_en = 1'b0;

        // Stream of 10 with a 3-cycle downstream stall
        fork
            begin
                for (int i = 1; i <= 10; i++) send(i, 2 * i, -1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                held = out_data;
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_hold_data", out_data, held);
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);

        // Bias load on the edge where the first pixel enters stage 2 and the second enters stage 1
        send(1, 1, 1);
        in_data  = {16'd2, 16'd2, 16'd2};
        in_valid = 1'b1;
        bias_we  = 1'b1;
        bias_in  = 16'd50;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bias_we  = 1'b0;
        idle(4);

        // Reset during a stall
        out_ready = 1'b0;
        send(9, 9, 9);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = out_valid;
        end
        chk("stall_before_reset", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_eol", out_eol, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;

        // Framing after reset; first beat shows the reset bias value
        base = log_d.size();
        chk("pre_reset_beats", base, 17);
        for (int k = 1; k <= 9; k++) send(k - 1, 0, 0);
        idle(4);

        chk("total_beats", log_d.size(), 26);
        if (log_d.size() >= 26) begin
            chk("beat0_sum_bias5", log_d[0], 92);
            chk("beat1_sat_pos", log_d[1], 32767);
            chk("beat2_sat_neg", log_d[2], -32768);
            chk("beat3_relu_neg", log_d[3], 0);
            chk("beat4_relu_pos", log_d[4], 10);
            for (int i = 1; i <= 10; i++) chk("stream_order", log_d[4 + i], 3 * i - 1);
            chk("bias_old", log_d[15], 3);
            chk("bias_new", log_d[16], 56);
            for (int k = 1; k <= 9; k++) begin
                chk("frame_data", log_d[16 + k], k + 6);
                chk("frame_eol", log_eol[16 + k], (k == 4 || k == 8));
                chk("frame_eof", log_eof[16 + k], (k == 8));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
